// File: rtl/accel_sample_assembler.sv
// accel_sample_assembler
//
// Rebuilds 16-bit X/Y/Z samples from the 6-byte ADXL345 burst read
// (DATAX0..DATAZ1). It then averages 2^AVG_SHIFT consecutive frames and
// presents the result together with a tilt bargraph derived from X.
//
// Ports
//   CLOCK_50     in   system clock; all state changes on the rising edge
//   reset_n      in   asynchronous active-low reset
//   RX_DATA      in   [7:0] byte delivered by the I2C master
//   RX_VALID     in   one-cycle strobe qualifying RX_DATA
//   FRAME_START  in   marks the first byte of a burst (only meaningful with RX_VALID)
//   X_OUT        out  [15:0] averaged signed X sample
//   Y_OUT        out  [15:0] averaged signed Y sample
//   Z_OUT        out  [15:0] averaged signed Z sample
//   SAMPLE_VALID out  one-cycle pulse when X/Y/Z_OUT take a new value
//   FRAME_ERR    out  one-cycle pulse on a malformed frame
//   LED          out  [7:0] one-hot tilt bargraph from X_OUT
//
// Outputs are registered, so SAMPLE_VALID, X/Y/Z_OUT and LED all change on
// the edge that leaves OUTPUT. That edge is two edges after the last byte
// of the window was captured.
module accel_sample_assembler #(
    parameter int AVG_SHIFT = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic        FRAME_START,
    output logic [15:0] X_OUT,
    output logic [15:0] Y_OUT,
    output logic [15:0] Z_OUT,
    output logic        SAMPLE_VALID,
    output logic        FRAME_ERR,
    output logic [7:0]  LED
);

    localparam int ACC_W = 16 + AVG_SHIFT;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ACCUM   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [2:0]           byte_cnt_reg, byte_cnt_next;
    logic [AVG_SHIFT-1:0] frame_cnt_reg, frame_cnt_next;

    // Control strobes from the FSM into the datapath
    logic       wr_en;
    logic [2:0] wr_idx;
    logic       do_accum;
    logic       do_output;
    logic       frame_err_next;

    logic       sample_valid_reg;
    logic       frame_err_reg;
    logic [7:0] led_reg, led_next;

    logic [7:0]  frame_byte [6];
    logic [15:0] axis_avg   [3];
    logic [15:0] axis_out   [3];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            byte_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        wr_en          = 1'b0;
        wr_idx         = 3'd0;
        do_accum       = 1'b0;
        do_output      = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // Unframed bytes are silently dropped here
                if (RX_VALID && FRAME_START) begin
                    wr_en         = 1'b1;
                    wr_idx        = 3'd0;
                    byte_cnt_next = 3'd1;
                    state_next    = COLLECT;
                end
            end

            COLLECT: begin
                if (RX_VALID) begin
                    wr_en = 1'b1;
                    if (FRAME_START) begin
                        // A new burst began before the old one finished:
                        // abandon the partial frame and restart on this byte.
                        frame_err_next = 1'b1;
                        wr_idx         = 3'd0;
                        byte_cnt_next  = 3'd1;
                    end else begin
                        wr_idx = byte_cnt_reg;
                        if (byte_cnt_reg == 3'd5) begin
                            byte_cnt_next = 3'd0;
                            state_next    = ACCUM;
                        end else begin
                            byte_cnt_next = byte_cnt_reg + 3'd1;
                        end
                    end
                end
            end

            ACCUM: begin
                do_accum       = 1'b1;
                frame_cnt_next = frame_cnt_reg + AVG_SHIFT'(1);
                // Counter about to wrap means this was the window's last frame
                if (frame_cnt_reg == {AVG_SHIFT{1'b1}}) begin
                    state_next = OUTPUT;
                end else begin
                    state_next = IDLE;
                end
                if (RX_VALID && FRAME_START) begin
                    frame_err_next = 1'b1;
                end
            end

            OUTPUT: begin
                do_output  = 1'b1;
                state_next = IDLE;
                if (RX_VALID && FRAME_START) begin
                    frame_err_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame byte store: byte gi lands in its own register
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_byte
            logic [7:0] data_reg;

            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    data_reg <= '0;
                end else if (wr_en && (wr_idx == 3'(gi))) begin
                    data_reg <= RX_DATA;
                end
            end

            assign frame_byte[gi] = data_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-axis accumulate and average. Sample gi is {byte 2gi+1, byte 2gi}.
    // The accumulator is AVG_SHIFT bits wider than a sample, so summing
    // 2^AVG_SHIFT samples cannot overflow. The arithmetic shift floors
    // toward minus infinity.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            logic [15:0]             sample;
            logic signed [ACC_W-1:0] acc_reg;
            logic [15:0]             out_reg;

            assign sample       = {frame_byte[2*gi+1], frame_byte[2*gi]};
            assign axis_avg[gi] = 16'(acc_reg >>> AVG_SHIFT);
            assign axis_out[gi] = out_reg;

            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    acc_reg <= '0;
                    out_reg <= '0;
                end else if (do_accum) begin
                    acc_reg <= acc_reg + ACC_W'($signed(sample));
                end else if (do_output) begin
                    out_reg <= axis_avg[gi];
                    acc_reg <= '0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bargraph: {~sign, next two bits} is X in offset binary, top 3 bits.
    // It is decoded from the value X_OUT is about to take, so LED moves
    // on the same edge as X_OUT.
    // ------------------------------------------------------------------
    always_comb begin
        led_next = led_reg;
        if (do_output) begin
            led_next = 8'd1 << {~axis_avg[0][15], axis_avg[0][14:13]};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sample_valid_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            led_reg          <= 8'h10;
        end else begin
            sample_valid_reg <= do_output;
            frame_err_reg    <= frame_err_next;
            led_reg          <= led_next;
        end
    end

    assign X_OUT        = axis_out[0];
    assign Y_OUT        = axis_out[1];
    assign Z_OUT        = axis_out[2];
    assign SAMPLE_VALID = sample_valid_reg;
    assign FRAME_ERR    = frame_err_reg;
    assign LED          = led_reg;

endmodule

// File: tb/tb_accel_sample_assembler.sv
// tb_accel_sample_assembler
//
// Drives ADXL345-style 6-byte bursts into accel_sample_assembler.
// Expected averages come from plain integer sums and floor division.
// Expected LED values come from the offset-binary octant of X.
// One line is printed per averaged sample produced.
module tb_accel_sample_assembler;

    localparam int AVG_SHIFT = 2;
    localparam int NF        = 1 << AVG_SHIFT;

    logic        CLOCK_50    = 1'b0;
    logic        reset_n     = 1'b0;
    logic [7:0]  RX_DATA     = 8'h00;
    logic        RX_VALID    = 1'b0;
    logic        FRAME_START = 1'b0;
    logic [15:0] X_OUT;
    logic [15:0] Y_OUT;
    logic [15:0] Z_OUT;
    logic        SAMPLE_VALID;
    logic        FRAME_ERR;
    logic [7:0]  LED;

    accel_sample_assembler #(.AVG_SHIFT(AVG_SHIFT)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .FRAME_START  (FRAME_START),
        .X_OUT        (X_OUT),
        .Y_OUT        (Y_OUT),
        .Z_OUT        (Z_OUT),
        .SAMPLE_VALID (SAMPLE_VALID),
        .FRAME_ERR    (FRAME_ERR),
        .LED          (LED)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    int cyc           = 0;
    int sv_count      = 0;
    int fe_count      = 0;
    int sv_cyc        = 0;
    int last_byte_cyc = 0;
    logic [15:0] cap_x = '0, cap_y = '0, cap_z = '0;
    logic [7:0]  cap_led = '0;

    // Expected outputs of the previous window (what must be held)
    logic [15:0] prev_x = '0, prev_y = '0, prev_z = '0;
    logic [7:0]  prev_led = 8'h10;

    // Frames for the next window
    logic [15:0] wx [NF];
    logic [15:0] wy [NF];
    logic [15:0] wz [NF];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Pulse recorder, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (SAMPLE_VALID === 1'b1) begin
            sv_count <= sv_count + 1;
            sv_cyc   <= cyc;
            cap_x    <= X_OUT;
            cap_y    <= Y_OUT;
            cap_z    <= Z_OUT;
            cap_led  <= LED;
        end
        if (FRAME_ERR === 1'b1) begin
            fe_count <= fe_count + 1;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic int floor_div(input int sum);
        int r;
        r = sum % NF;
        if (r < 0) r = r + NF;
        return (sum - r) / NF;
    endfunction

    function automatic logic [7:0] led_of(input logic [15:0] x);
        int sx;
        int idx;
        sx  = int'($signed(x));
        idx = (sx + 32768) / 8192;
        return 8'(1 << idx);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Quiet cycle; FRAME_START toggles randomly because it must be ignored
    // without RX_VALID.
    task automatic idle_cycle();
        RX_VALID    = 1'b0;
        RX_DATA     = 8'($urandom);
        FRAME_START = 1'($urandom_range(0, 1));
        tick();
        FRAME_START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic st);
        RX_DATA     = d;
        RX_VALID    = 1'b1;
        FRAME_START = st;
        tick();
        RX_VALID    = 1'b0;
        FRAME_START = 1'b0;
    endtask

    // Sends the first nbytes of a frame. With a full frame, inject extra
    // start-flagged bytes right after the last byte (they land in ACCUM and
    // OUTPUT), then leave a quiet gap.
    task automatic send_frame(input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] z, input int nbytes,
                              input int inject);
        logic [7:0] b [6];
        b[0] = x[7:0]; b[1] = x[15:8];
        b[2] = y[7:0]; b[3] = y[15:8];
        b[4] = z[7:0]; b[5] = z[15:8];
        for (int i = 0; i < nbytes; i++) begin
            if (i > 0) repeat ($urandom_range(0, 1)) idle_cycle();
            send_byte(b[i], (i == 0));
        end
        if (nbytes == 6) begin
            last_byte_cyc = cyc;
            repeat (inject) send_byte(8'($urandom), 1'b1);
            repeat (3) idle_cycle();
        end
    endtask

    // Sends the NF frames in wx/wy/wz and checks the resulting sample.
    task automatic check_window(input string name, input int exp_err,
                                input int lat_chk, input int inject_last);
        int sv0, fe0, sx, sy, sz, v;
        logic [15:0] ex, ey, ez;
        logic [7:0]  el;
        sv0 = sv_count;
        fe0 = fe_count;
        sx = 0; sy = 0; sz = 0;
        for (int f = 0; f < NF; f++) begin
            sx += int'($signed(wx[f]));
            sy += int'($signed(wy[f]));
            sz += int'($signed(wz[f]));
            send_frame(wx[f], wy[f], wz[f], 6, (f == NF - 1) ? inject_last : 0);
            if (f < NF - 1) begin
                total++;
                if (sv_count !== sv0) begin
                    bad++;
                    $display("FAIL %s early_sample: frame %0d got %0d pulses want 0", name, f, sv_count - sv0);
                end
                total++;
                if (X_OUT !== prev_x || Y_OUT !== prev_y || Z_OUT !== prev_z || LED !== prev_led) begin
                    bad++;
                    $display("FAIL %s hold: got %h/%h/%h led %h want %h/%h/%h led %h",
                             name, X_OUT, Y_OUT, Z_OUT, LED, prev_x, prev_y, prev_z, prev_led);
                end
            end
        end
        for (int k = 0; k < 20 && sv_count == sv0; k++) tick();

        v = floor_div(sx); ex = v[15:0];
        v = floor_div(sy); ey = v[15:0];
        v = floor_div(sz); ez = v[15:0];
        el = led_of(ex);

        total++;
        if (sv_count !== sv0 + 1) begin
            bad++;
            $display("FAIL %s sample_count: got %0d want 1", name, sv_count - sv0);
        end
        total++;
        if (cap_x !== ex) begin
            bad++;
            $display("FAIL %s x_out: got %h want %h", name, cap_x, ex);
        end
        total++;
        if (cap_y !== ey) begin
            bad++;
            $display("FAIL %s y_out: got %h want %h", name, cap_y, ey);
        end
        total++;
        if (cap_z !== ez) begin
            bad++;
            $display("FAIL %s z_out: got %h want %h", name, cap_z, ez);
        end
        total++;
        if (cap_led !== el) begin
            bad++;
            $display("FAIL %s led: got %h want %h", name, cap_led, el);
        end
        total++;
        if (fe_count - fe0 !== exp_err) begin
            bad++;
            $display("FAIL %s frame_err_count: got %0d want %0d", name, fe_count - fe0, exp_err);
        end
        if (lat_chk != 0) begin
            total++;
            if (sv_cyc - last_byte_cyc !== 2) begin
                bad++;
                $display("FAIL %s latency: got %0d edges want 2", name, sv_cyc - last_byte_cyc);
            end
        end
        total++;
        if (X_OUT !== ex || LED !== el) begin
            bad++;
            $display("FAIL %s hold_after: got %h led %h want %h led %h", name, X_OUT, LED, ex, el);
        end
        $display("sample %s: x=%h y=%h z=%h led=%h (expected %h %h %h %h)",
                 name, cap_x, cap_y, cap_z, cap_led, ex, ey, ez, el);
        prev_x = ex; prev_y = ey; prev_z = ez; prev_led = el;
    endtask

    task automatic randomize_window();
        for (int f = 0; f < NF; f++) begin
            wx[f] = 16'($urandom);
            wy[f] = 16'($urandom);
            wz[f] = 16'($urandom);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (X_OUT !== 16'h0 || Y_OUT !== 16'h0 || Z_OUT !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h/%h/%h want 0000/0000/0000", X_OUT, Y_OUT, Z_OUT);
        end
        total++;
        if (SAMPLE_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses: got sv=%b fe=%b want 0/0", SAMPLE_VALID, FRAME_ERR);
        end
        total++;
        if (LED !== 8'h10) begin
            bad++;
            $display("FAIL reset_led: got %h want 10", LED);
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        tick();
        prev_x = '0; prev_y = '0; prev_z = '0; prev_led = 8'h10;
    endtask

    task automatic test_basic();
        for (int f = 0; f < NF; f++) begin
            wx[f] = 16'h0100;
            wy[f] = 16'hFF00;
            wz[f] = 16'h0010;
        end
        check_window("basic", 0, 1, 0);
    endtask

    task automatic test_floor();
        randomize_window();
        wx[0] = 16'hFFFF; wx[1] = 16'hFFFF; wx[2] = 16'hFFFF; wx[3] = 16'h0000;
        check_window("floor", 0, 1, 0);
    endtask

    task automatic test_random();
        for (int w = 0; w < 4; w++) begin
            randomize_window();
            check_window($sformatf("random%0d", w), 0, 1, 0);
        end
    endtask

    task automatic test_frame_err();
        randomize_window();
        // Three bytes of a doomed frame; the next start byte aborts it
        send_frame(16'($urandom), 16'($urandom), 16'($urandom), 3, 0);
        check_window("frame_err", 1, 1, 0);
    endtask

    task automatic test_stray();
        int fe0;
        fe0 = fe_count;
        repeat ($urandom_range(3, 6)) begin
            send_byte(8'($urandom), 1'b0);
            idle_cycle();
        end
        total++;
        if (fe_count !== fe0) begin
            bad++;
            $display("FAIL stray_err: got %0d pulses want 0", fe_count - fe0);
        end
        randomize_window();
        check_window("stray", 0, 1, 0);
    endtask

    task automatic test_accum_err();
        randomize_window();
        check_window("accum_err", 2, 1, 2);
        randomize_window();
        check_window("after_accum_err", 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        repeat (2) send_frame(16'($urandom), 16'($urandom), 16'($urandom), 6, 0);
        send_frame(16'($urandom), 16'($urandom), 16'($urandom), 2, 0);
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (X_OUT !== 16'h0 || Y_OUT !== 16'h0 || Z_OUT !== 16'h0 || LED !== 8'h10) begin
            bad++;
            $display("FAIL async_reset: got %h/%h/%h led %h want 0000/0000/0000 led 10",
                     X_OUT, Y_OUT, Z_OUT, LED);
        end
        total++;
        if (SAMPLE_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_pulses: got sv=%b fe=%b want 0/0", SAMPLE_VALID, FRAME_ERR);
        end
        repeat (2) tick();
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        tick();
        prev_x = '0; prev_y = '0; prev_z = '0; prev_led = 8'h10;
        randomize_window();
        check_window("after_reset", 0, 1, 0);
    endtask

    task automatic test_extremes();
        randomize_window();
        for (int f = 0; f < NF; f++) wx[f] = 16'h7FFF;
        check_window("max_pos", 0, 1, 0);
        randomize_window();
        for (int f = 0; f < NF; f++) wx[f] = 16'h8000;
        check_window("max_neg", 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_random();
        test_frame_err();
        test_stray();
        test_accum_err();
        test_reset_mid();
        test_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/accel_sample_assembler.md
ACCEL_SAMPLE_ASSEMBLER -- requirements
Module: accel_sample_assembler

Interface
REQ-001 The block SHALL have one parameter: AVG_SHIFT, default 2, log2 of the averaging window in samples (legal values 1..3).
REQ-002 The block SHALL have these ports:
- CLOCK_50  in  1  system clock, 50 MHz; single clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- RX_DATA  in  8  byte read from the ADXL345 by the I2C master.
- RX_VALID  in  1  one-cycle strobe qualifying RX_DATA.
- FRAME_START  in  1  one-cycle pulse marking the first byte of a 6-byte burst read from register 8'h32 (DATAX0).
- X_OUT  out  16  averaged signed X sample.
- Y_OUT  out  16  averaged signed Y sample.
- Z_OUT  out  16  averaged signed Z sample.
- SAMPLE_VALID  out  1  one-cycle pulse when X/Y/Z_OUT update.
- FRAME_ERR  out  1  one-cycle pulse on a malformed frame.
- LED  out  8  tilt bargraph derived from X_OUT.

Function
REQ-003 The block SHALL use states IDLE, COLLECT, ACCUM and OUTPUT, plus a 3-bit byte counter and an AVG_SHIFT-bit frame counter.
REQ-004 In IDLE, RX_VALID with FRAME_START in the same cycle SHALL store RX_DATA as byte 0, set the byte counter to 1 and enter COLLECT.
REQ-005 In IDLE, RX_VALID without FRAME_START SHALL be ignored (byte dropped, no error).
REQ-006 FRAME_START without RX_VALID SHALL be ignored in every state.
REQ-007 In COLLECT, each RX_VALID without FRAME_START SHALL store RX_DATA at the byte-counter index and increment the counter.
REQ-008 The byte order SHALL be X_lo, X_hi, Y_lo, Y_hi, Z_lo, Z_hi; each axis sample SHALL be {hi, lo} as 16-bit two's complement.
REQ-009 When the 6th byte is stored, the FSM SHALL enter ACCUM on the next edge.
REQ-010 In COLLECT, RX_VALID together with FRAME_START SHALL:
- discard the partial frame;
- pulse FRAME_ERR for one cycle;
- store RX_DATA as byte 0 with the byte counter set to 1;
- stay in COLLECT.
REQ-011 In ACCUM (one cycle), each axis sample SHALL be sign-extended and added into a (16+AVG_SHIFT)-bit signed accumulator (no overflow is possible), and the frame counter SHALL increment.
REQ-012 If the frame counter wraps to 0 (2^AVG_SHIFT frames accumulated), the FSM SHALL enter OUTPUT; otherwise it SHALL return to IDLE.
REQ-013 In OUTPUT (one cycle):
- X/Y/Z_OUT SHALL load accumulator >>> AVG_SHIFT (arithmetic shift, floor rounding);
- SAMPLE_VALID SHALL be high for exactly that cycle;
- the accumulators SHALL clear;
- the FSM SHALL return to IDLE.
REQ-014 Latency: SAMPLE_VALID SHALL be high in the cycle starting two rising edges after the edge that captured the final byte of the window's last frame.
REQ-015 RX_VALID arriving in ACCUM or OUTPUT SHALL be dropped; if FRAME_START is asserted with it, FRAME_ERR SHALL pulse.
REQ-016 X/Y/Z_OUT SHALL hold their values between SAMPLE_VALID pulses.
REQ-017 LED SHALL be the registered one-hot decode of index {~X_OUT[15], X_OUT[14:13]}: X_OUT=0 -> 8'h10, most negative -> 8'h01, most positive -> 8'h80.
REQ-018 LED SHALL update in the same cycle as X_OUT.

Reset
REQ-019 While reset_n is low, regardless of clock, the block SHALL force:
- FSM to IDLE;
- byte and frame counters to 0;
- accumulators to 0;
- X_OUT, Y_OUT and Z_OUT to 16'h0000;
- SAMPLE_VALID and FRAME_ERR to 0;
- LED to 8'h10.
REQ-020 Reset mid-frame or mid-window SHALL discard all partial data; the first SAMPLE_VALID after release SHALL need 2^AVG_SHIFT complete new frames.

Verification
REQ-021 AVG_SHIFT=2, four frames of bytes 00 01 00 FF 10 00 -> one SAMPLE_VALID; X_OUT=16'h0100, Y_OUT=16'hFF00, Z_OUT=16'h0010, LED=8'h10.
REQ-022 Four frames with X=-1,-1,-1,0 -> X_OUT=16'hFFFF (floor of -0.75); SAMPLE_VALID two edges after the last byte.
REQ-023 FRAME_START with RX_VALID after 3 bytes -> one FRAME_ERR pulse, no accumulation; the window then needs four more good frames.
REQ-024 Stray RX_VALID bytes in IDLE -> no state change, no FRAME_ERR; the next correctly framed burst assembles normally.
REQ-025 reset_n low after two good frames -> outputs 0 and LED=8'h10 immediately; four new frames are then required for SAMPLE_VALID.
REQ-026 Four frames with X=16'h7FFF -> X_OUT=16'h7FFF, LED=8'h80; four frames with X=16'h8000 -> X_OUT=16'h8000, LED=8'h01.
